// File: rtl/clause_load_sequencer.sv
// Clause load sequencer: packs a serial host word stream into per-engine
// clauses, pointer vectors and unit-clause literals, and issues one-cycle
// registered load pulses into the engine load buffer.
module clause_load_sequencer #(
  parameter int LIT_IDX_MAX = 1024,
  parameter int NUM_CLAUSE  = 8,
  parameter int CLA_LENGTH  = 3,
  parameter int NUM_ENGINE  = 1,
  parameter int CLQ_DEPTH   = 64,
  localparam int LIT_W      = $clog2(LIT_IDX_MAX) + 1,
  localparam int PTR_W      = $clog2(CLQ_DEPTH)
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 start_in,
  input  logic [LIT_W-1:0]                     word_in,
  input  logic                                 word_valid_in,
  output logic                                 word_ready_out,
  output logic [NUM_ENGINE*CLA_LENGTH*LIT_W-1:0] clause_out,
  output logic                                 load_clause_out,
  output logic [NUM_ENGINE*PTR_W-1:0]          ptr_out,
  output logic                                 load_ptr_out,
  output logic [LIT_W-1:0]                     uc_out,
  output logic                                 load_uc_out,
  output logic                                 busy_out,
  output logic                                 done_out,
  output logic                                 err_out
);

  // One slot per (engine, literal); slot index = eng * CLA_LENGTH + lit,
  // which matches the word arrival order, so a single counter walks it.
  localparam int NUM_SLOT = NUM_ENGINE * CLA_LENGTH;
  localparam int SLOT_W   = $clog2(NUM_SLOT + 1);
  localparam int CLA_W    = $clog2(NUM_CLAUSE + 1);
  localparam int ENG_W    = $clog2(NUM_ENGINE + 1);
  localparam int CLA_BITS = NUM_SLOT * LIT_W;
  localparam int PTR_BITS = NUM_ENGINE * PTR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLA,
    S_PTR,
    S_UC,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [CLA_W-1:0]    cla_cnt_q, cla_cnt_d;
  logic [ENG_W-1:0]    eng_q, eng_d;
  logic [CLA_BITS-1:0] asm_q, asm_d;
  logic [PTR_BITS-1:0] pasm_q, pasm_d;
  logic [CLA_BITS-1:0] clause_q, clause_d;
  logic [PTR_BITS-1:0] ptr_q, ptr_d;
  logic [LIT_W-1:0]    uc_q, uc_d;
  logic                load_clause_q, load_clause_d;
  logic                load_ptr_q, load_ptr_d;
  logic                load_uc_q, load_uc_d;
  logic                err_q, err_d;
  logic                xfer;
  logic                ptr_bad;

  // Ready depends on state only so the host never sees a valid->ready loop.
  assign word_ready_out = (state_q == S_CLA) || (state_q == S_PTR) || (state_q == S_UC);
  assign xfer           = word_valid_in && word_ready_out;
  // Negative words or words past the queue depth are out of range.
  assign ptr_bad        = word_in[LIT_W-1] || (word_in >= LIT_W'(CLQ_DEPTH));

  // Next-state, assembly and load-pulse generation.
  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    cla_cnt_d     = cla_cnt_q;
    eng_d         = eng_q;
    asm_d         = asm_q;
    pasm_d        = pasm_q;
    clause_d      = clause_q;
    ptr_d         = ptr_q;
    uc_d          = uc_q;
    err_d         = err_q;
    load_clause_d = 1'b0;
    load_ptr_d    = 1'b0;
    load_uc_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_in) begin
          err_d     = 1'b0;
          slot_d    = '0;
          cla_cnt_d = '0;
          eng_d     = '0;
          state_d   = S_CLA;
        end
      end
      S_CLA: begin
        if (xfer) begin
          asm_d[int'(slot_q)*LIT_W +: LIT_W] = word_in;
          if (slot_q == SLOT_W'(NUM_SLOT - 1)) begin
            // Completed group includes the word arriving this cycle.
            slot_d        = '0;
            clause_d      = asm_d;
            load_clause_d = 1'b1;
            cla_cnt_d     = cla_cnt_q + CLA_W'(1);
            if (cla_cnt_q == CLA_W'(NUM_CLAUSE - 1)) state_d = S_PTR;
          end else begin
            slot_d = slot_q + SLOT_W'(1);
          end
        end
      end
      S_PTR: begin
        if (xfer) begin
          // Out-of-range pointers are flagged but still loaded truncated.
          pasm_d[int'(eng_q)*PTR_W +: PTR_W] = word_in[PTR_W-1:0];
          if (ptr_bad) err_d = 1'b1;
          if (eng_q == ENG_W'(NUM_ENGINE - 1)) begin
            eng_d      = '0;
            ptr_d      = pasm_d;
            load_ptr_d = 1'b1;
            state_d    = S_UC;
          end else begin
            eng_d = eng_q + ENG_W'(1);
          end
        end
      end
      S_UC: begin
        if (xfer) begin
          if (word_in != '0) begin
            uc_d      = word_in;
            load_uc_d = 1'b1;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, counters, assembly and output registers; reset discards any partial group.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      slot_q        <= '0;
      cla_cnt_q     <= '0;
      eng_q         <= '0;
      asm_q         <= '0;
      pasm_q        <= '0;
      clause_q      <= '0;
      ptr_q         <= '0;
      uc_q          <= '0;
      err_q         <= 1'b0;
      load_clause_q <= 1'b0;
      load_ptr_q    <= 1'b0;
      load_uc_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      cla_cnt_q     <= cla_cnt_d;
      eng_q         <= eng_d;
      asm_q         <= asm_d;
      pasm_q        <= pasm_d;
      clause_q      <= clause_d;
      ptr_q         <= ptr_d;
      uc_q          <= uc_d;
      err_q         <= err_d;
      load_clause_q <= load_clause_d;
      load_ptr_q    <= load_ptr_d;
      load_uc_q     <= load_uc_d;
    end
  end

  assign clause_out      = clause_q;
  assign load_clause_out = load_clause_q;
  assign ptr_out         = ptr_q;
  assign load_ptr_out    = load_ptr_q;
  assign uc_out          = uc_q;
  assign load_uc_out     = load_uc_q;
  assign busy_out        = word_ready_out;
  assign done_out        = (state_q == S_DONE);
  assign err_out         = err_q;

endmodule
